// File: rtl/control_sequencer_if.sv
// Sequencer bundle: IR opcode and ALU flags in, control word, T-state and halt status out.
interface control_sequencer_if #(
    parameter int STEP_W = 3
);
    logic [3:0]        opcode;
    logic              flag_carry;
    logic              flag_zero;
    logic [15:0]       ctrl;
    logic [STEP_W-1:0] step;
    logic              halted;

    modport master (output opcode, flag_carry, flag_zero, input ctrl, step, halted);
    modport slave  (input opcode, flag_carry, flag_zero, output ctrl, step, halted);
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-state counter plus combinational decode of (step, opcode, flags).
// Optional STEP_SKIP_EN: return to T0 as soon as the next microstep would issue no signals.
module control_sequencer #(
    parameter int STEPS  = 5,
    parameter int STEP_W = 3
) (
    input  logic                clk,
    input  logic                clear,
    control_sequencer_if.slave  bus
);
    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t            state;
    logic [STEP_W-1:0] step;
    logic [15:0]       ctrl_dec;
    logic              step_last;
    logic              skip;

    // Microcode ROM; any T-state beyond T4 or unlisted opcode issues nothing.
    function automatic logic [15:0] decode(input int unsigned t, input logic [3:0] op,
                                           input logic fc, input logic fz);
        logic [15:0] w;
        w = '0;
        case (t)
            0: w = C_MI | C_CO;
            1: w = C_RO | C_II | C_CE;
            2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w = C_IO | C_MI;
                    OP_LDI: w = C_IO | C_AI;
                    OP_JMP: w = C_IO | C_J;
                    OP_JC:  w = fc ? (C_IO | C_J) : '0;
                    OP_JZ:  w = fz ? (C_IO | C_J) : '0;
                    OP_OUT: w = C_AO | C_OI;
                    OP_HLT: w = C_HLT;
                    default: w = '0;
                endcase
            end
            3: begin
                case (op)
                    OP_LDA:         w = C_RO | C_AI;
                    OP_ADD, OP_SUB: w = C_RO | C_BI;
                    OP_STA:         w = C_AO | C_RI;
                    default:        w = '0;
                endcase
            end
            4: begin
                case (op)
                    OP_ADD:  w = C_EO | C_AI | C_FI;
                    OP_SUB:  w = C_EO | C_SU | C_AI | C_FI;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        ctrl_dec  = decode(32'(step), bus.opcode, bus.flag_carry, bus.flag_zero);
        step_last = (32'(step) == 32'(STEPS - 1));
    end

`ifdef STEP_SKIP_EN
    logic [15:0] ctrl_peek;

    // Look one microstep ahead; an empty word means the instruction is already done.
    always_comb begin
        ctrl_peek = decode(32'(step) + 32'd1, bus.opcode, bus.flag_carry, bus.flag_zero);
        skip      = (step >= STEP_W'(2)) && (ctrl_peek == 16'h0000);
    end
`else
    always_comb skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= S_RUN;
            step  <= '0;
        end else if (state == S_RUN) begin
            // The halting step freezes the counter where it is.
            if (ctrl_dec[15])
                state <= S_HALT;
            else if (step_last || skip)
                step <= '0;
            else
                step <= step + 1'b1;
        end
    end

    assign bus.ctrl   = (state == S_HALT) ? C_HLT : ctrl_dec;
    assign bus.step   = step;
    assign bus.halted = (state == S_HALT);
endmodule
